fmadd_normalize_seq: RTL and testbench

- Iterative post-addition normalizer for the FMADD datapath.
- Takes the raw, unnormalized significand sum from the adder (carry, hidden, fraction and GRS bits) with its sign and exponent.
- Shifts one bit per cycle until the result is normalized or the exponent floor is reached.
- Presents mantissa, exponent, sign, guard/round/sticky and a zero flag to the addition rounding block under a valid/ready handshake.

---
 rtl/fmadd_normalize_seq_if.sv | 35 +++
 rtl/fmadd_normalize_seq.sv | 115 +++++++++++
 tb/tb_fmadd_normalize_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fmadd_normalize_seq_if.sv
// Handshake and data bundle carrying the raw adder sum into the normalizer and
// the normalized result out towards the addition rounding block.
interface fmadd_normalize_seq_if #(
    parameter int MAN = 22,
    parameter int EXP = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [MAN+4:0]   in_sum;
    logic             in_sticky;
    logic [EXP+1:0]   in_exponent;
    logic             in_sign;

    logic             out_valid;
    logic             out_ready;
    logic [MAN+1:0]   out_mantissa;
    logic [EXP+1:0]   out_exponent;
    logic             out_sign;
    logic             out_guard;
    logic             out_round;
    logic             out_sticky;
    logic             out_zero;

    modport master (
        output in_valid, in_sum, in_sticky, in_exponent, in_sign, out_ready,
        input  in_ready, out_valid, out_mantissa, out_exponent, out_sign,
               out_guard, out_round, out_sticky, out_zero
    );

    modport slave (
        input  in_valid, in_sum, in_sticky, in_exponent, in_sign, out_ready,
        output in_ready, out_valid, out_mantissa, out_exponent, out_sign,
               out_guard, out_round, out_sticky, out_zero
    );
endinterface

// File: rtl/fmadd_normalize_seq.sv
// Iterative FMADD post-add normalizer: one shift per cycle, 2 edges + 1 per left shift from accept to out_valid.
// One word in flight: in_ready drops on accept and returns only after out_ready retires the held result.
module fmadd_normalize_seq #(
    parameter int STD = 31,
    parameter int MAN = 22,
    parameter int EXP = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    fmadd_normalize_seq_if.slave bus
);
    localparam int SIG_W = STD - EXP;
    localparam logic [EXP+1:0] E_ONE = {{(EXP+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t           state_q;
    logic [MAN+4:0]   vec_q, vec_d;
    logic             sacc_q, sacc_d;
    logic [EXP+1:0]   e_q, e_d;
    logic             s_q;
    logic             fin_d, zero_d;

    logic             in_ready_q, out_valid_q;
    logic [SIG_W-1:0] mant_q;
    logic [EXP+1:0]   oexp_q;
    logic             osign_q, og_q, or_q, os_q, oz_q;

    // One normalization decision per cycle; a carry always finishes, so it never mixes with left shifts.
    always_comb begin
        vec_d  = vec_q;
        sacc_d = sacc_q;
        e_d    = e_q;
        fin_d  = 1'b0;
        if (vec_q[MAN+4]) begin
            vec_d  = vec_q >> 1;
            sacc_d = sacc_q | vec_q[0];
            e_d    = e_q + E_ONE;
            fin_d  = 1'b1;
        end else if (vec_q[MAN+3] || (e_q <= E_ONE) || ((vec_q == '0) && !sacc_q)) begin
            fin_d  = 1'b1;
        end else begin
            vec_d  = vec_q << 1;
            e_d    = e_q - E_ONE;
        end
        zero_d = (vec_d == '0) && !sacc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            sacc_q      <= 1'b0;
            e_q         <= '0;
            s_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mant_q      <= '0;
            oexp_q      <= '0;
            osign_q     <= 1'b0;
            og_q        <= 1'b0;
            or_q        <= 1'b0;
            os_q        <= 1'b0;
            oz_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec_q      <= bus.in_sum;
                        sacc_q     <= bus.in_sticky;
                        e_q        <= (bus.in_exponent == '0) ? E_ONE : bus.in_exponent;
                        s_q        <= bus.in_sign;
                        in_ready_q <= 1'b0;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    vec_q  <= vec_d;
                    sacc_q <= sacc_d;
                    e_q    <= e_d;
                    if (fin_d) begin
                        // Stored fraction field is zero-extended into the wider rounding-block port.
                        mant_q      <= SIG_W'(vec_d[MAN+3:3]);
                        og_q        <= vec_d[2];
                        or_q        <= vec_d[1];
                        os_q        <= vec_d[0] | sacc_d;
                        oexp_q      <= zero_d ? '0 : e_d;
                        oz_q        <= zero_d;
                        osign_q     <= s_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_mantissa = mant_q;
    assign bus.out_exponent = oexp_q;
    assign bus.out_sign     = osign_q;
    assign bus.out_guard    = og_q;
    assign bus.out_round    = or_q;
    assign bus.out_sticky   = os_q;
    assign bus.out_zero     = oz_q;
endmodule

// File: tb/tb_fmadd_normalize_seq.sv
// Bench for fmadd_normalize_seq: directed vector table, reset abort, then random words vs a leading-one model.
module tb_fmadd_normalize_seq;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fmadd_normalize_seq_if #(.MAN(22), .EXP(7)) bus ();

    fmadd_normalize_seq #(.STD(31), .MAN(22), .EXP(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] sum;
        logic        stk;
        logic [8:0]  ex;
        logic        sg;
        logic [23:0] mant;
        logic [8:0]  e;
        logic        gd;
        logic        rd;
        logic        sd;
        logic        z;
        int          edges;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Normalize by locating the leading one and shifting in one step, clamped at exponent 1.
    function automatic vec_t model(input logic [26:0] sum, input logic stk,
                                   input logic [8:0] ex, input logic sg);
        vec_t        r;
        int          p;
        int          sh;
        logic [26:0] v;
        logic [8:0]  e;
        logic        sa;
        r.sum = sum; r.stk = stk; r.ex = ex; r.sg = sg;
        e  = (ex == 9'd0) ? 9'd1 : ex;
        v  = sum;
        sa = stk;
        sh = 0;
        if (sum[26]) begin
            sa = stk | sum[0];
            v  = sum >> 1;
            e  = e + 9'd1;
        end else begin
            p = -1;
            for (int b = 0; b < 26; b++) if (sum[b]) p = b;
            if (p >= 0)   sh = 25 - p;
            else if (stk) sh = 511;
            if (sh > int'(e) - 1) sh = int'(e) - 1;
            v = sum << sh;
            e = e - 9'(sh);
        end
        r.z     = (v == 27'd0) && !sa;
        r.mant  = {1'b0, v[25:3]};
        r.e     = r.z ? 9'd0 : e;
        r.gd    = v[2];
        r.rd    = v[1];
        r.sd    = v[0] | sa;
        r.edges = 2 + sh;
        return r;
    endfunction

    task automatic run_op(input vec_t v, input int hold);
        int          edges;
        logic        got;
        logic        stable;
        logic [40:0] snap;
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1'b1);
        bus.in_sum      = v.sum;
        bus.in_sticky   = v.stk;
        bus.in_exponent = v.ex;
        bus.in_sign     = v.sg;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        edges = 1;
        got   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            chk("in_ready_busy", bus.in_ready, 1'b0);
            @(posedge clk);
            edges++;
        end
        chk("out_valid_timeout", got, 1'b1);
        if (got) begin
            chk("latency", edges, v.edges);
            chk("mantissa", bus.out_mantissa, v.mant);
            chk("exponent", bus.out_exponent, v.e);
            chk("sign", bus.out_sign, v.sg);
            chk("grs", {bus.out_guard, bus.out_round, bus.out_sticky}, {v.gd, v.rd, v.sd});
            chk("zero", bus.out_zero, v.z);
            snap = {bus.out_mantissa, bus.out_exponent, bus.out_sign, bus.out_guard,
                    bus.out_round, bus.out_sticky, bus.out_zero, bus.out_valid, bus.in_ready};
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                if (snap !== {bus.out_mantissa, bus.out_exponent, bus.out_sign, bus.out_guard,
                              bus.out_round, bus.out_sticky, bus.out_zero, bus.out_valid,
                              bus.in_ready})
                    stable = 1'b0;
            end
            if (hold > 0) chk("hold_stable", stable, 1'b1);
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("retire_valid", bus.out_valid, 1'b0);
            chk("retire_ready", bus.in_ready, 1'b1);
        end
    endtask

    initial begin
        vec_t        tbl[12];
        vec_t        v;
        logic        seen;
        logic [26:0] s;
        int          mode;

        checks   = 0;
        failures = 0;
        tbl[0]  = '{27'h4000000, 1'b0, 9'd127, 1'b0, 24'h400000, 9'd128, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[1]  = '{27'h4000001, 1'b0, 9'd100, 1'b1, 24'h400000, 9'd101, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[2]  = '{27'h0000008, 1'b0, 9'd127, 1'b0, 24'h400000, 9'd105, 1'b0, 1'b0, 1'b0, 1'b0, 24};
        tbl[3]  = '{27'h0000008, 1'b0, 9'd10,  1'b0, 24'h000200, 9'd1,   1'b0, 1'b0, 1'b0, 1'b0, 11};
        tbl[4]  = '{27'h0000000, 1'b0, 9'd90,  1'b1, 24'h000000, 9'd0,   1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[5]  = '{27'h0000000, 1'b1, 9'd90,  1'b0, 24'h000000, 9'd1,   1'b0, 1'b0, 1'b1, 1'b0, 91};
        tbl[6]  = '{27'h0000008, 1'b0, 9'd0,   1'b0, 24'h000001, 9'd1,   1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[7]  = '{27'h2000007, 1'b0, 9'd50,  1'b0, 24'h400000, 9'd50,  1'b1, 1'b1, 1'b1, 1'b0, 2};
        tbl[8]  = '{27'h1000005, 1'b0, 9'd50,  1'b1, 24'h400001, 9'd49,  1'b0, 1'b1, 1'b0, 1'b0, 3};
        tbl[9]  = '{27'h4000002, 1'b0, 9'h1FF, 1'b0, 24'h400000, 9'd0,   1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[10] = '{27'h0000004, 1'b0, 9'd30,  1'b0, 24'h400000, 9'd7,   1'b0, 1'b0, 1'b0, 1'b0, 25};
        tbl[11] = '{27'h0000000, 1'b1, 9'd1,   1'b0, 24'h000000, 9'd1,   1'b0, 1'b0, 1'b1, 1'b0, 2};

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_sum      = '0;
        bus.in_sticky   = 1'b0;
        bus.in_exponent = '0;
        bus.in_sign     = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_data", {bus.out_mantissa, bus.out_exponent, bus.out_sign, bus.out_guard,
                         bus.out_round, bus.out_sticky, bus.out_zero}, 41'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_op(tbl[i], (i == 0) ? 5 : (i * 3) % 7);

        // Reset during the fifth left shift must drop the word without ever presenting it.
        @(negedge clk);
        bus.in_sum      = tbl[2].sum;
        bus.in_sticky   = tbl[2].stk;
        bus.in_exponent = tbl[2].ex;
        bus.in_sign     = tbl[2].sg;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_never_valid", seen, 1'b0);
        run_op(tbl[0], 0);

        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       s = {1'b1, 26'($urandom)};
                1:       s = 27'({1'b0, 26'($urandom)} >> $urandom_range(0, 26));
                2:       s = 27'd0;
                default: s = {2'b01, 25'($urandom)};
            endcase
            v = model(s, 1'($urandom), 9'($urandom), 1'($urandom));
            run_op(v, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
